// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop sync plus per-channel stability debounce for slide switches
// Optional rise/fall pulses are built only when DEBOUNCE_EDGE_EN is defined.
module switch_debounce #(
    parameter int WIDTH      = 5,
    parameter int STABLE_CNT = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             ready
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W:0]   INIT_LAST = (CNT_W + 1)'(STABLE_CNT + 2);

    state_t           state;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [CNT_W:0]   init_cnt;
    logic [WIDTH-1:0] accept;

    // A channel accepts its new level on the edge its count would pass STABLE_CNT-1.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != sw_out[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sw_out <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == sw_out[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    sw_out[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // ready rises one edge after the power-up levels have had time to land on sw_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else if (ready) begin
            rise <= accept & sync2;
            fall <= accept & ~sync2;
        end else begin
            rise <= '0;
            fall <= '0;
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - scoreboard bench for switch_debounce with STABLE_CNT=4
module tb_switch_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sw_in;
    logic [4:0] sw_out;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef DEBOUNCE_EDGE_EN
    localparam logic [4:0] EDGE_MASK = 5'b11111;
`else
    localparam logic [4:0] EDGE_MASK = 5'b00000;
`endif

    typedef struct {
        int         edge_n;
        logic [4:0] sw;
        logic [4:0] r;
        logic [4:0] f;
        logic       rdy;
    } exp_t;

    exp_t q[$];

    switch_debounce #(
        .WIDTH      (5),
        .STABLE_CNT (4),
        .CNT_W      (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .rise   (rise),
        .fall   (fall),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every edge that has a queued expectation is compared at the following negedge.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].edge_n < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL stale_expectation edge %0d not compared (now %0d)", q[0].edge_n, cyc);
            void'(q.pop_front());
        end
        if (q.size() != 0 && q[0].edge_n == cyc) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (sw_out !== e.sw || rise !== e.r || fall !== e.f || ready !== e.rdy) begin
                n_fail++;
                $display("FAIL edge_%0d got sw_out=%b rise=%b fall=%b ready=%b expected sw_out=%b rise=%b fall=%b ready=%b",
                         e.edge_n, sw_out, rise, fall, ready, e.sw, e.r, e.f, e.rdy);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int edge_n, input logic [4:0] sw, input logic [4:0] r,
                        input logic [4:0] f, input logic rdy);
        exp_t e;
        e.edge_n = edge_n;
        e.sw     = sw;
        e.r      = r & EDGE_MASK;
        e.f      = f & EDGE_MASK;
        e.rdy    = rdy;
        q.push_back(e);
    endtask

    task automatic steady(input int a, input int b, input logic [4:0] sw, input logic rdy);
        for (int i = a; i <= b; i++) push(i, sw, 5'b0, 5'b0, rdy);
    endtask

    // New pin level before edge k lands on sw_out (with pulses) at edge k+5.
    task automatic settle(input logic [4:0] new_in, input logic [4:0] old_out,
                          input logic [4:0] new_out, input logic [4:0] r, input logic [4:0] f);
        int k;
        sw_in = new_in;
        k = cyc + 1;
        steady(k, k + 4, old_out, 1'b1);
        push(k + 5, new_out, r, f, 1'b1);
        steady(k + 6, k + 7, new_out, 1'b1);
        tick(8);
    endtask

    task automatic power_up(input logic [4:0] pins);
        int e;
        rst = 1'b1;
        push(cyc + 1, 5'b0, 5'b0, 5'b0, 1'b0);
        tick(1);
        rst   = 1'b0;
        sw_in = pins;
        e = cyc + 1;
        steady(e, e + 4, 5'b0, 1'b0);
        steady(e + 5, e + 5, pins, 1'b0);
        steady(e + 6, e + 8, pins, 1'b1);
        tick(9);
    endtask

    initial begin
        int k;
        logic [4:0] bounce [5];
        rst   = 1'b1;
        sw_in = 5'b0;

        power_up(5'b10110);

        settle(5'b10111, 5'b10110, 5'b10111, 5'b00001, 5'b00000);

        settle(5'b00111, 5'b10111, 5'b00111, 5'b00000, 5'b10000);
        sw_in = 5'b10111;
        k = cyc + 1;
        steady(k, k + 9, 5'b00111, 1'b1);
        tick(3);
        sw_in = 5'b00111;
        tick(7);
        settle(5'b10111, 5'b00111, 5'b10111, 5'b10000, 5'b00000);

        settle(5'b10011, 5'b10111, 5'b10011, 5'b00000, 5'b00100);
        bounce[0] = 5'b10111;
        bounce[1] = 5'b10011;
        bounce[2] = 5'b10111;
        bounce[3] = 5'b10111;
        bounce[4] = 5'b10011;
        k = cyc + 1;
        steady(k, k + 9, 5'b10011, 1'b1);
        push(k + 10, 5'b10111, 5'b00100, 5'b00000, 1'b1);
        steady(k + 11, k + 12, 5'b10111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sw_in = bounce[i];
            tick(1);
        end
        sw_in = 5'b10111;
        tick(8);

        settle(5'b01000, 5'b10111, 5'b01000, 5'b01000, 5'b10111);
        settle(5'b00010, 5'b01000, 5'b00010, 5'b00010, 5'b01000);

        sw_in = 5'b00011;
        k = cyc + 1;
        steady(k, k + 3, 5'b00010, 1'b1);
        tick(4);
        power_up(5'b00011);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain %0d expectations left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
